// File: rtl/frv_mem_responder_pkg.sv
// Shared types and address-check helpers for the memory responder.
// The response entry layout is used by both the queue and the top level.
package frv_mem_responder_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } mem_rsp_t;

    localparam logic [1:0] MEM_ERR_ALIGN_MASK = 2'b11;
    localparam int unsigned MEM_ERR_ADDR_W = 33;

    // Extra bit keeps the upper bound from wrapping when the window ends at 4 GiB.
    function automatic logic mem_err_check(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [MEM_ERR_ADDR_W-1:0] lo;
        logic [MEM_ERR_ADDR_W-1:0] hi;
        logic [MEM_ERR_ADDR_W-1:0] a;
        lo = {1'b0, base};
        hi = lo + (MEM_ERR_ADDR_W'(words) << 2);
        a  = {1'b0, addr};
        return ((addr[1:0] & MEM_ERR_ALIGN_MASK) != 2'b00) || (a < lo) || (a >= hi);
    endfunction

endpackage

// File: rtl/frv_mem_responder_if.sv
// Request/response bus between an initiator port of the core and the memory responder.
// The stall hook lives here so a bench can throttle grants from the initiator side.
interface frv_mem_responder_if;

    logic        mem_req;
    logic        mem_wen;
    logic [3:0]  mem_strb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_recv;
    logic        mem_ack;
    logic        mem_error;
    logic [31:0] mem_rdata;
    logic        stall;

    modport master (
        output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack, stall,
        input  mem_gnt, mem_recv, mem_error, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr, mem_ack, stall,
        output mem_gnt, mem_recv, mem_error, mem_rdata
    );

endinterface

// File: rtl/frv_mem_rsp_fifo.sv
// In-order queue of pending responses; head is visible combinationally.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module frv_mem_rsp_fifo
    import frv_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  mem_rsp_t         push_data_i,
    input  logic             pop_i,
    output mem_rsp_t         head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    mem_rsp_t         store_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/frv_mem_responder.sv
// Memory-side responder: word-addressed SRAM, range check at accept, and an
// in-order response queue whose head is released after RSP_LATENCY cycles.
module frv_mem_responder
    import frv_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned RSP_LATENCY = 1,
    parameter int unsigned RSP_DEPTH   = 2
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    frv_mem_responder_if.slave    mem
);

    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int unsigned WAIT_W = (RSP_LATENCY > 1) ? $clog2(RSP_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(RSP_LATENCY - 1);

    logic [31:0]       sram_q [MEM_WORDS];
    logic [IDX_W-1:0]  word_idx;
    logic              addr_err;
    logic              accept;
    logic              push;
    logic              pop;
    logic              head_ready;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    mem_rsp_t          push_rsp;
    mem_rsp_t          head_rsp;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;

    assign addr_err = mem_err_check(mem.mem_addr, BASE_ADDR, MEM_WORDS);
    assign word_idx = IDX_W'((mem.mem_addr - BASE_ADDR) >> 2);

    // Grant uses the registered count, so a full queue being popped still refuses this cycle.
    assign mem.mem_gnt = g_resetn & mem.mem_req & ~mem.stall
                       & (fifo_count < CNT_W'(RSP_DEPTH));
    assign accept      = mem.mem_req & mem.mem_gnt;
    assign push        = accept & ~fifo_full;

    always_comb begin
        push_rsp.rdata = 32'h0;
        push_rsp.error = addr_err;
        if (!addr_err && !mem.mem_wen) begin
            push_rsp.rdata = sram_q[word_idx];
        end
    end

    // Writes commit at the accept edge so any later read sees the new bytes.
    always_ff @(posedge g_clk) begin
        if (push && mem.mem_wen && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (mem.mem_strb[b]) begin
                    sram_q[word_idx][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
                end
            end
        end
    end

    frv_mem_rsp_fifo #(
        .DEPTH       (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (g_clk),
        .rst_n       (g_resetn),
        .push_i      (push),
        .push_data_i (push_rsp),
        .pop_i       (pop),
        .head_o      (head_rsp),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_ready = ~fifo_empty & (wait_q == WAIT_MAX);
    assign pop        = head_ready & mem.mem_ack;

    // A fresh head restarts the wait, whether it arrived into an empty queue or was exposed by a pop.
    always_comb begin
        wait_d = wait_q;
        if (pop || (push && fifo_empty)) begin
            wait_d = '0;
        end else if (!fifo_empty && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    assign mem.mem_recv  = head_ready;
    assign mem.mem_rdata = head_ready ? head_rsp.rdata : 32'h0;
    assign mem.mem_error = head_ready & head_rsp.error;

endmodule
